// File: rtl/core_pkg.sv
// Shared core constants and helpers for register-file side logic.
//   REG_ADDR_W : architectural register index width
//   NUM_REGS   : number of architectural registers (x0 hardwired to zero)
//   XLEN       : default datapath width
//   slice_lo   : low bit of element idx inside a packed bundle of width-bit fields
package core_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned XLEN       = 32;

  // Low bit index of field idx in a bundle packed as [w*idx+w-1 : w*idx].
  function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/regfile_wb_ctrl_rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter.
// The search starts at ptr and wraps; the first asserted request wins.
// Ports:
//   req     in  N      request vector
//   ptr     in  PTR_W  current priority pointer (0..N-1)
//   gnt     out N      one-hot grant, all-zero when req is zero
//   ptr_nxt out PTR_W  pointer after this cycle's grant ((winner+1) mod N),
//                      equal to ptr when nothing is granted
module rr_arbiter
  import core_pkg::*;
#(
  parameter int unsigned N = 3,
  localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [PTR_W-1:0] ptr_nxt
);

  logic             w_found;
  logic [PTR_W-1:0] w_idx;

  // Scan N positions starting at ptr; take the first valid one.
  always_comb begin
    gnt     = '0;
    ptr_nxt = ptr;
    w_found = 1'b0;
    w_idx   = '0;
    for (int unsigned off = 0; off < N; off++) begin
      w_idx = PTR_W'((32'(ptr) + off) % N);
      if (!w_found && req[w_idx]) begin
        w_found    = 1'b1;
        gnt[w_idx] = 1'b1;
        ptr_nxt    = PTR_W'((32'(w_idx) + 32'd1) % N);
      end
    end
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl: write-back controller for the 32x32 register file.
// Shares the single regfile write port among NREQ producers with round-robin
// arbitration and a registered output stage, and keeps a per-register
// pending-write scoreboard that drives the issue-stage hazard signal.
//
// Build option: define REGFILE_WB_BYPASS_EN to clear busy bits on acceptance
// and forward the registered write-back data to the read operands. Without
// it, busy bits clear at the regfile commit edge and the bypass is tied off.
//
// Parameters: NREQ (2..8) requesters, XLEN data width.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/req_rd/req_data     per-requester result bundles (packed slices)
//   req_ready                     one-hot grant (combinational)
//   iss_valid, iss_rd             issue of an instruction writing iss_rd
//   rs1, rs2                      sources of the instruction in issue
//   hazard                        RAW/WAW stall request (combinational)
//   rsX_byp_en, rsX_byp_data      forwarding from the write-back register
//   rf_wr_en, rf_addr_d, rf_data_d  registered regfile write port
module regfile_wb_ctrl
  import core_pkg::REG_ADDR_W, core_pkg::NUM_REGS, core_pkg::slice_lo;
#(
  parameter int unsigned NREQ = 3,
  parameter int unsigned XLEN = core_pkg::XLEN
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [REG_ADDR_W*NREQ-1:0] req_rd,
  input  logic [XLEN*NREQ-1:0]       req_data,
  output logic [NREQ-1:0]            req_ready,
  input  logic                       iss_valid,
  input  logic [REG_ADDR_W-1:0]      iss_rd,
  input  logic [REG_ADDR_W-1:0]      rs1,
  input  logic [REG_ADDR_W-1:0]      rs2,
  output logic                       hazard,
  output logic                       rs1_byp_en,
  output logic                       rs2_byp_en,
  output logic [XLEN-1:0]            rs1_byp_data,
  output logic [XLEN-1:0]            rs2_byp_data,
  output logic                       rf_wr_en,
  output logic [REG_ADDR_W-1:0]      rf_addr_d,
  output logic [XLEN-1:0]            rf_data_d
);

  localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PTR_W-1:0]      r_ptr;
  logic [PTR_W-1:0]      w_ptr_nxt;
  logic [NREQ-1:0]       w_gnt;
  logic                  w_xfer;
  logic [REG_ADDR_W-1:0] w_sel_rd;
  logic [XLEN-1:0]       w_sel_data;
  logic [NUM_REGS-1:0]   r_busy;
  logic [NUM_REGS-1:0]   w_busy_nxt;
  logic                  w_clr_en;
  logic [REG_ADDR_W-1:0] w_clr_rd;

  logic [REG_ADDR_W-1:0] w_rd_arr   [NREQ];
  logic [XLEN-1:0]       w_data_arr [NREQ];

  // Unpack the request bundles.
  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign w_rd_arr[g]   = req_rd[slice_lo(g, REG_ADDR_W) +: REG_ADDR_W];
    assign w_data_arr[g] = req_data[slice_lo(g, XLEN) +: XLEN];
  end

  // Grant never looks at rf_*: the output stage accepts every cycle.
  rr_arbiter #(
    .N (NREQ)
  ) u_arb (
    .req     (req_valid),
    .ptr     (r_ptr),
    .gnt     (w_gnt),
    .ptr_nxt (w_ptr_nxt)
  );

  assign req_ready = w_gnt;
  assign w_xfer    = |(req_valid & w_gnt);

  // One-hot AND-OR mux of the granted requester's rd/data.
  always_comb begin
    w_sel_rd   = '0;
    w_sel_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      w_sel_rd   = w_sel_rd   | (w_rd_arr[i]   & {REG_ADDR_W{w_gnt[i]}});
      w_sel_data = w_sel_data | (w_data_arr[i] & {XLEN{w_gnt[i]}});
    end
  end

`ifdef REGFILE_WB_BYPASS_EN
  // Clear on acceptance; the value is forwarded from rf_* next cycle.
  assign w_clr_en     = w_xfer;
  assign w_clr_rd     = w_sel_rd;
  assign rs1_byp_en   = rf_wr_en && (rf_addr_d == rs1);
  assign rs2_byp_en   = rf_wr_en && (rf_addr_d == rs2);
  assign rs1_byp_data = rf_data_d;
  assign rs2_byp_data = rf_data_d;
`else
  // Clear at the commit edge; rf_addr_d is the registered accepted rd.
  assign w_clr_en     = rf_wr_en;
  assign w_clr_rd     = rf_addr_d;
  assign rs1_byp_en   = 1'b0;
  assign rs2_byp_en   = 1'b0;
  assign rs1_byp_data = '0;
  assign rs2_byp_data = '0;
`endif

  // Scoreboard update: set has priority over a same-cycle clear.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_clr_en) begin
      w_busy_nxt[w_clr_rd] = 1'b0;
    end
    if (iss_valid && (iss_rd != '0)) begin
      w_busy_nxt[iss_rd] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  assign hazard = r_busy[rs1] | r_busy[rs2] | (iss_valid & r_busy[iss_rd]);

  // Pointer, scoreboard and write-port registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr     <= '0;
      r_busy    <= '0;
      rf_wr_en  <= 1'b0;
      rf_addr_d <= '0;
      rf_data_d <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      if (w_xfer) begin
        r_ptr     <= w_ptr_nxt;
        rf_wr_en  <= (w_sel_rd != '0);
        rf_addr_d <= w_sel_rd;
        rf_data_d <= w_sel_data;
      end else begin
        rf_wr_en  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Testbench for regfile_wb_ctrl (NREQ=3, XLEN=32). Honors REGFILE_WB_BYPASS_EN.
module tb_regfile_wb_ctrl;

  localparam int unsigned NREQ = 3;
  localparam int unsigned XLEN = 32;
`ifdef REGFILE_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [5*NREQ-1:0] req_rd;
  logic [XLEN*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              iss_valid;
  logic [4:0]        iss_rd, rs1, rs2;
  logic              hazard;
  logic              rs1_byp_en, rs2_byp_en;
  logic [XLEN-1:0]   rs1_byp_data, rs2_byp_data;
  logic              rf_wr_en;
  logic [4:0]        rf_addr_d;
  logic [XLEN-1:0]   rf_data_d;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_wb_ctrl #(.NREQ(NREQ), .XLEN(XLEN)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_rd       (req_rd),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .iss_valid    (iss_valid),
    .iss_rd       (iss_rd),
    .rs1          (rs1),
    .rs2          (rs2),
    .hazard       (hazard),
    .rs1_byp_en   (rs1_byp_en),
    .rs2_byp_en   (rs2_byp_en),
    .rs1_byp_data (rs1_byp_data),
    .rs2_byp_data (rs2_byp_data),
    .rf_wr_en     (rf_wr_en),
    .rf_addr_d    (rf_addr_d),
    .rf_data_d    (rf_data_d)
  );

  typedef struct {
    logic        rst;
    logic [2:0]  vld;
    logic [14:0] rd;
    logic [95:0] data;
    logic        iv;
    logic [4:0]  ird;
    logic [4:0]  s1;
    logic [4:0]  s2;
    logic [2:0]  e_rdy;
    logic        e_haz;
    logic        e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic        e_b1;
    logic        e_b2;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(
    input logic rs, input logic [2:0] vld,
    input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2,
    input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
    input logic iv, input logic [4:0] ird, input logic [4:0] s1, input logic [4:0] s2,
    input logic [2:0] rdy, input logic haz, input logic we, input logic [4:0] addr,
    input logic [31:0] dat, input logic b1, input logic b2);
    vec_t v;
    v.rst = rs; v.vld = vld; v.rd = {r2, r1, r0}; v.data = {d2, d1, d0};
    v.iv = iv; v.ird = ird; v.s1 = s1; v.s2 = s2;
    v.e_rdy = rdy; v.e_haz = haz; v.e_we = we; v.e_addr = addr; v.e_data = dat;
    v.e_b1 = b1; v.e_b2 = b2;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic idle_inputs();
    req_valid = '0; req_rd = '0; req_data = '0;
    iss_valid = 1'b0; iss_rd = '0; rs1 = '0; rs2 = '0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();

    // rst, vld, r0,r1,r2, d0,d1,d2, iv,ird,rs1,rs2, rdy,haz,we,addr,data, b1,b2
    // reset state / single write
    vq.push_back(mk(0,3'b000, 0,0,0, 0,0,0, 0,0,0,0, 3'b000,0,0,0,0, 0,0));
    vq.push_back(mk(0,3'b001, 5,0,0, 32'h1A2B3C4D,0,0, 0,0,0,0, 3'b001,0,0,0,0, 0,0));
    vq.push_back(mk(0,3'b000, 0,0,0, 0,0,0, 0,0,5,0, 3'b000,0,1,5,32'h1A2B3C4D, BYP,0));
    vq.push_back(mk(0,3'b000, 0,0,0, 0,0,0, 0,0,0,0, 3'b000,0,0,5,32'h1A2B3C4D, 0,0));
    // round-robin from reset
    vq.push_back(mk(1,3'b000, 0,0,0, 0,0,0, 0,0,0,0, 3'b000,0,0,5,32'h1A2B3C4D, 0,0));
    vq.push_back(mk(0,3'b111, 1,2,3, 32'h11,32'h22,32'h33, 0,0,0,0, 3'b001,0,0,0,0, 0,0));
    vq.push_back(mk(0,3'b111, 1,2,3, 32'h11,32'h22,32'h33, 0,0,0,0, 3'b010,0,1,1,32'h11, 0,0));
    vq.push_back(mk(0,3'b111, 1,2,3, 32'h11,32'h22,32'h33, 0,0,0,0, 3'b100,0,1,2,32'h22, 0,0));
    vq.push_back(mk(0,3'b111, 1,2,3, 32'h11,32'h22,32'h33, 0,0,0,0, 3'b001,0,1,3,32'h33, 0,0));
    vq.push_back(mk(0,3'b111, 1,2,3, 32'h11,32'h22,32'h33, 0,0,0,0, 3'b010,0,1,1,32'h11, 0,0));
    vq.push_back(mk(0,3'b111, 1,2,3, 32'h11,32'h22,32'h33, 0,0,0,0, 3'b100,0,1,2,32'h22, 0,0));
    vq.push_back(mk(0,3'b000, 0,0,0, 0,0,0, 0,0,0,0, 3'b000,0,1,3,32'h33, 0,0));
    // write-back to x0: accepted, no write enable
    vq.push_back(mk(0,3'b001, 0,0,0, 32'hFFFFFFFF,0,0, 0,0,0,0, 3'b001,0,0,3,32'h33, 0,0));
    vq.push_back(mk(0,3'b000, 0,0,0, 0,0,0, 0,0,0,0, 3'b000,0,0,0,32'hFFFFFFFF, 0,0));
    // pointer wrap with sparse requests (ptr=1 here)
    vq.push_back(mk(0,3'b101, 4,0,6, 32'h44,0,32'h66, 0,0,0,0, 3'b100,0,0,0,32'hFFFFFFFF, 0,0));
    vq.push_back(mk(0,3'b101, 4,0,6, 32'h44,0,32'h66, 0,0,0,0, 3'b001,0,1,6,32'h66, 0,0));
    vq.push_back(mk(0,3'b010, 0,8,0, 0,32'h88,0, 0,0,0,0, 3'b010,0,1,4,32'h44, 0,0));
    vq.push_back(mk(0,3'b011, 10,8,0, 32'hA0,32'h88,0, 0,0,0,0, 3'b001,0,1,8,32'h88, 0,0));
    vq.push_back(mk(0,3'b000, 0,0,0, 0,0,0, 0,0,0,0, 3'b000,0,1,10,32'hA0, 0,0));
    vq.push_back(mk(0,3'b000, 0,0,0, 0,0,0, 0,0,0,0, 3'b000,0,0,10,32'hA0, 0,0));
    // scoreboard: issue x7, RAW on rs1 until write-back
    vq.push_back(mk(0,3'b000, 0,0,0, 0,0,0, 1,7,0,0, 3'b000,0,0,10,32'hA0, 0,0));
    vq.push_back(mk(0,3'b000, 0,0,0, 0,0,0, 0,0,7,0, 3'b000,1,0,10,32'hA0, 0,0));
    vq.push_back(mk(0,3'b000, 0,0,0, 0,0,0, 0,0,7,0, 3'b000,1,0,10,32'hA0, 0,0));
    vq.push_back(mk(0,3'b010, 0,7,0, 0,32'hDEADBEEF,0, 0,0,7,0, 3'b010,1,0,10,32'hA0, 0,0));
    vq.push_back(mk(0,3'b000, 0,0,0, 0,0,0, 0,0,7,0, 3'b000,!BYP,1,7,32'hDEADBEEF, BYP,0));
    vq.push_back(mk(0,3'b000, 0,0,0, 0,0,0, 0,0,7,0, 3'b000,0,0,7,32'hDEADBEEF, 0,0));
    // same-cycle set/clear on x9: set wins
    vq.push_back(mk(0,3'b000, 0,0,0, 0,0,0, 1,9,0,0, 3'b000,0,0,7,32'hDEADBEEF, 0,0));
    vq.push_back(mk(0,3'b001, 9,0,0, 32'h99,0,0, 1,9,0,9, 3'b001,1,0,7,32'hDEADBEEF, 0,0));
    vq.push_back(mk(0,3'b000, 0,0,0, 0,0,0, 1,9,0,9, 3'b000,1,1,9,32'h99, 0,BYP));
    vq.push_back(mk(0,3'b000, 0,0,0, 0,0,0, 0,0,0,9, 3'b000,1,0,9,32'h99, 0,0));
    vq.push_back(mk(0,3'b100, 0,0,9, 0,0,32'h9A, 0,0,0,9, 3'b100,1,0,9,32'h99, 0,0));
    vq.push_back(mk(0,3'b000, 0,0,0, 0,0,0, 0,0,0,9, 3'b000,!BYP,1,9,32'h9A, 0,BYP));
    vq.push_back(mk(0,3'b000, 0,0,0, 0,0,0, 0,0,0,9, 3'b000,0,0,9,32'h9A, 0,0));
    // reset mid-stream with busy[3] set and all requesters valid
    vq.push_back(mk(0,3'b000, 0,0,0, 0,0,0, 1,3,0,0, 3'b000,0,0,9,32'h9A, 0,0));
    vq.push_back(mk(0,3'b111, 11,12,13, 32'hB,32'hC,32'hD, 0,0,3,0, 3'b001,1,0,9,32'h9A, 0,0));
    vq.push_back(mk(1,3'b111, 11,12,13, 32'hB,32'hC,32'hD, 0,0,3,0, 3'b010,1,1,11,32'hB, 0,0));
    vq.push_back(mk(0,3'b111, 11,12,13, 32'hB,32'hC,32'hD, 0,0,3,0, 3'b001,0,0,0,0, 0,0));
    vq.push_back(mk(0,3'b000, 0,0,0, 0,0,0, 0,0,3,0, 3'b000,0,1,11,32'hB, 0,0));
    // issue to x0 never marks busy
    vq.push_back(mk(0,3'b000, 0,0,0, 0,0,0, 1,0,0,0, 3'b000,0,0,11,32'hB, 0,0));
    vq.push_back(mk(0,3'b000, 0,0,0, 0,0,0, 0,0,0,0, 3'b000,0,0,11,32'hB, 0,0));

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Inputs change 1 time unit after the edge, outputs sampled at negedge.
    for (int k = 0; k < vq.size(); k++) begin
      rst = vq[k].rst; req_valid = vq[k].vld; req_rd = vq[k].rd; req_data = vq[k].data;
      iss_valid = vq[k].iv; iss_rd = vq[k].ird; rs1 = vq[k].s1; rs2 = vq[k].s2;
      @(negedge clk);
      chk($sformatf("v%0d req_ready", k), 64'(req_ready), 64'(vq[k].e_rdy));
      chk($sformatf("v%0d hazard", k), 64'(hazard), 64'(vq[k].e_haz));
      chk($sformatf("v%0d rf_wr_en", k), 64'(rf_wr_en), 64'(vq[k].e_we));
      chk($sformatf("v%0d rf_addr_d", k), 64'(rf_addr_d), 64'(vq[k].e_addr));
      chk($sformatf("v%0d rf_data_d", k), 64'(rf_data_d), 64'(vq[k].e_data));
      chk($sformatf("v%0d rs1_byp_en", k), 64'(rs1_byp_en), 64'(vq[k].e_b1));
      chk($sformatf("v%0d rs2_byp_en", k), 64'(rs2_byp_en), 64'(vq[k].e_b2));
      chk($sformatf("v%0d rs1_byp_data", k), 64'(rs1_byp_data), BYP ? 64'(vq[k].e_data) : 64'd0);
      chk($sformatf("v%0d rs2_byp_data", k), 64'(rs2_byp_data), BYP ? 64'(vq[k].e_data) : 64'd0);
      @(posedge clk);
      #1;
    end

    // Sustained traffic from reset: strict rotation, port busy every cycle.
    rst = 1'b1;
    idle_inputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
    req_valid = 3'b111;
    req_rd    = {5'd3, 5'd2, 5'd1};
    req_data  = {32'h3, 32'h2, 32'h1};
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      chk($sformatf("rr3 c%0d grant", c), 64'(req_ready), 64'(3'b001 << (c % 3)));
      if (c > 0) chk($sformatf("rr3 c%0d rf_wr_en", c), 64'(rf_wr_en), 64'd1);
      @(posedge clk);
      #1;
    end

    // Two requesters (ptr back at 0): alternate 001/010.
    req_valid = 3'b011;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("rr2a c%0d grant", c), 64'(req_ready), (c % 2 == 0) ? 64'd1 : 64'd2);
      @(posedge clk);
      #1;
    end

    // Requesters 1 and 2 with ptr at 2: alternate 100/010.
    req_valid = 3'b110;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("rr2b c%0d grant", c), 64'(req_ready), (c % 2 == 0) ? 64'd4 : 64'd2);
      @(posedge clk);
      #1;
    end

    idle_inputs();
    @(negedge clk);
    chk("drain req_ready", 64'(req_ready), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_ctrl.md
# regfile_wb_ctrl

Write-back controller for the core's 32×32 register file. It shares the file's single write port (`wr_en`/`addr_d`/`data_d`) among NREQ result producers, such as the ALU, the load unit and the multi-cycle mul/div, using round-robin arbitration and a registered output stage. It also keeps a per-register pending-write scoreboard, which the issue stage uses to stall on RAW/WAW hazards. It sits between the execute units and `regfile`, beside the decode/issue logic.

## Interface
- `NREQ`, default 3: number of write-back requesters; legal range 2..8.
- `XLEN`, default 32: data width.
- `clk` in 1: single clock; every register updates on its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in NREQ: requester i has a result.
- `req_rd` in 5·NREQ: destination of requester i, packed as slice [5i+4:5i].
- `req_data` in XLEN·NREQ: result of requester i, packed as slice [XLEN·i+XLEN-1:XLEN·i].
- `req_ready` out NREQ: one-hot grant, combinational; a transfer occurs when `req_valid[i] & req_ready[i]`.
- `iss_valid` in 1: issue stage dispatches an instruction that writes `iss_rd`.
- `iss_rd` in 5: destination register of the issuing instruction.
- `rs1`, `rs2` in 5: source registers of the instruction in issue.
- `hazard` out 1: combinational; 1 when rs1, rs2 or iss_rd is pending.
- `rs1_byp_en`, `rs2_byp_en` out 1: a bypass value is valid (see Configuration).
- `rs1_byp_data`, `rs2_byp_data` out XLEN: bypass data.
- `rf_wr_en` out 1: connects to `regfile.wr_en`; registered.
- `rf_addr_d` out 5: connects to `regfile.addr_d`; registered.
- `rf_data_d` out XLEN: connects to `regfile.data_d`; registered.

## Operation
- **Arbitration.** Round-robin over the asserted `req_valid` bits, starting at pointer `ptr`.
  - At most one `req_ready` bit is high per cycle, and `req_ready` is all-zero when no request is valid.
  - `req_ready` never depends on `rf_*`; the output stage always drains.
  - After a grant to requester i, `ptr` becomes (i+1) mod NREQ. With no grant, `ptr` holds.
- **Output stage.** On a transfer, the next edge loads `rf_wr_en`=(rd≠0), `rf_addr_d`=rd and `rf_data_d`=data. Without a transfer, `rf_wr_en`=0 and the address and data registers hold.
  - A write-back to x0 is accepted and clears its handshake, but never asserts `rf_wr_en`.
- **Scoreboard.** `busy[31:1]`; `busy[0]` is permanently 0.
  - Set when `iss_valid` is high with `iss_rd`≠0.
  - Cleared when a transfer is accepted for that rd.
  - If a set and a clear hit the same register in the same cycle, the set wins.
- **Hazard.** `hazard` = busy[rs1] | busy[rs2] | (iss_valid & busy[iss_rd]).
  - The issue stage must not raise `iss_valid` while `hazard` is high. If it does anyway, the busy bit is simply set again; there is no error state.
- **Reset.** On reset: `busy`=0, `ptr`=0, `rf_wr_en`=0, `rf_addr_d`=0, `rf_data_d`=0, all `*_byp_en`=0. Any request or pending write in flight is discarded; producers must also be flushed by the same reset.

## Timing
- A result is accepted at edge N. The regfile commits it at edge N+1, and a read returns the new value from cycle N+1 onward.
- The busy bit drops at edge N, so `hazard` can deassert in cycle N.
  - Without bypass, the value is not yet in the file during cycle N. The clear is therefore delayed: the busy bit clears at the commit edge N+1.
  - With bypass, the busy bit clears at N and the data is forwarded from `rf_*` in cycle N+1.
  - Net effect: one bubble saved per dependency with bypass.
- Sustained throughput is one write-back per cycle. With k requesters continuously valid, each waits at most k-1 cycles between grants.

## Configuration
- `REGFILE_WB_BYPASS_EN` defined: the clear happens on acceptance, and `rsX_byp_en` = `rf_wr_en & (rf_addr_d==rsX)`, with `rsX_byp_data` = `rf_data_d`.
- `REGFILE_WB_BYPASS_EN` undefined: the clear happens one edge after acceptance, using a registered copy of the accepted rd. `rsX_byp_en` is tied to 0 and `rsX_byp_data` to 0.

## Structure
- Shared package `core_pkg` holds `REG_ADDR_W`=5, `NUM_REGS`=32, `XLEN`, and the packed-slice index helper for the request bundles.
- One sub-module, `rr_arbiter` (parameter N; inputs `req`, `ptr`; outputs one-hot `gnt` and the next `ptr`), is combinational and reusable for bus arbitration.
- The scoreboard and output stage stay in `regfile_wb_ctrl`.

## Test plan
- **Single write.** Apply req_valid=3'b001, rd=5, data=0x1A2B3C4D → req_ready=001 in the same cycle. The next cycle shows rf_wr_en=1, addr_d=5, data=0x1A2B3C4D, and the regfile reads 0x1A2B3C4D at rs1=5 one cycle later.
- **Round-robin.** Hold req_valid=3'b111 for 6 cycles from reset → grants 001, 010, 100, 001, 010, 100. No requester is starved, and rf_wr_en stays high continuously.
- **x0 write.** Apply req_valid=001, rd=0, data=0xFFFFFFFF → req_ready=001 and rf_wr_en stays 0. A regfile read of x0 returns 0.
- **Scoreboard.** Issue iss_rd=7, then set rs1=7 → hazard=1 until write-back. With bypass, hazard=0 and rs1_byp_en=1 with the data in the cycle after acceptance. Without bypass, hazard=0 one cycle later, with no byp_en.
- **Same-cycle set/clear.** Issue iss_rd=9 in the same cycle as a write-back with rd=9 → busy[9] remains 1 afterwards, and hazard=1 for rs2=9.
- **Reset mid-stream.** Assert rst for 1 cycle while req_valid=111 and busy[3]=1 → on the next cycle rf_wr_en=0, hazard=0 for rs1=3, and the first grant after reset is 001 (ptr=0).
